melody_sequencer: RTL

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer
// Plays a tune stored in a small note table as a square wave. Each entry holds a
// half-period divider (clock cycles, 0 = rest) and a duration in milliseconds.
// Every note is followed by a fixed silent gap. Playback starts on a rising edge
// of the asynchronous play input and either stops after 'length' entries (with a
// one-cycle done pulse) or wraps to entry 0 when loop is high.
//
// Ports
//   clk_100MHz  system clock
//   reset_n     asynchronous active-low reset
//   play        asynchronous start request, rising edge starts playback
//   stop        synchronous abort (level), forces IDLE on the next clock
//   loop        restart at entry 0 after the last note instead of finishing
//   length      number of entries to play (values above DEPTH act as DEPTH)
//   wr_en       note-table write strobe
//   wr_addr     note-table write address
//   wr_div      half-period in clock cycles, 0 = rest
//   wr_dur      note duration in ms, 0 behaves as 1 ms
//   speaker     square-wave output
//   busy        high whenever a note or gap is playing
//   note_idx    index of the current entry, held while idle
//   done        one-cycle pulse when a non-looped playback finishes
module melody_sequencer #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int DEPTH    = 64,
    parameter int DIV_W    = 20,
    parameter int DUR_W    = 12,
    parameter int GAP_MS   = 100
) (
    input  logic                     clk_100MHz,
    input  logic                     reset_n,
    input  logic                     play,
    input  logic                     stop,
    input  logic                     loop,
    input  logic [$clog2(DEPTH):0]   length,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DIV_W-1:0]         wr_div,
    input  logic [DUR_W-1:0]         wr_dur,
    output logic                     speaker,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] note_idx,
    output logic                     done
);

    localparam int AW         = $clog2(DEPTH);
    localparam int CYC_PER_MS = (CLK_FREQ / 1000 < 1) ? 1 : CLK_FREQ / 1000;
    localparam int PRE_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    // A zero gap would make the GAP state unterminated, so it lasts at least 1 ms.
    localparam int GAP_LEN    = (GAP_MS < 1) ? 1 : GAP_MS;
    localparam int GAP_W      = $clog2(GAP_LEN + 1);
    localparam int MS_W       = (DUR_W > GAP_W) ? DUR_W : GAP_W;

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_mem [DEPTH];
    logic [DUR_W-1:0]  dur_mem [DEPTH];
    logic [2:0]        play_sync;
    logic              play_prev;
    logic              play_edge;
    logic [PRE_W-1:0]  pre_cnt;
    logic [MS_W-1:0]   ms_cnt;
    logic [DIV_W-1:0]  tone_cnt;
    logic [DIV_W-1:0]  cur_div;
    logic [DUR_W-1:0]  cur_dur;
    logic [AW:0]       eff_len;
    logic              has_next;
    logic              ms_tick;
    logic [MS_W-1:0]   note_ms;
    logic [MS_W-1:0]   state_target;
    logic              state_end;
    logic              enter_note;
    logic [AW-1:0]     enter_idx;

    // Note table has no reset; an entry is copied into cur_div/cur_dur when the
    // entry is entered, so writes during playback only matter on the next entry.
    always_ff @(posedge clk_100MHz) begin
        if (wr_en) begin
            div_mem[wr_addr] <= wr_div;
            dur_mem[wr_addr] <= wr_dur;
        end
    end

    // Three-flop synchronizer followed by an edge detector on the synchronized level.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            play_sync <= '0;
            play_prev <= 1'b0;
        end else begin
            play_sync <= {play_sync[1:0], play};
            play_prev <= play_sync[2];
        end
    end

    assign play_edge = play_sync[2] & ~play_prev;

    // length is sampled here, so a mid-playback change only affects the decision
    // taken when a gap ends.
    always_comb begin
        eff_len      = (length > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : length;
        has_next     = ({1'b0, note_idx} + (AW+1)'(1)) < eff_len;
        ms_tick      = (pre_cnt == PRE_W'(CYC_PER_MS - 1));
        note_ms      = (cur_dur == '0) ? MS_W'(1) : MS_W'(cur_dur);
        state_target = (state == NOTE) ? note_ms : MS_W'(GAP_LEN);
        state_end    = ms_tick && (ms_cnt == state_target - MS_W'(1));
        enter_note   = 1'b0;
        enter_idx    = '0;
        case (state)
            IDLE: begin
                if (play_edge && eff_len != '0) begin
                    enter_note = 1'b1;
                end
            end
            GAP: begin
                if (state_end) begin
                    if (has_next) begin
                        enter_note = 1'b1;
                        enter_idx  = note_idx + AW'(1);
                    end else if (loop) begin
                        enter_note = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (stop) begin
            enter_note = 1'b0;
        end
    end

    // Main FSM. The ms prescaler and counter restart on every state entry so each
    // state lasts an exact whole number of milliseconds.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            speaker  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            note_idx <= '0;
            pre_cnt  <= '0;
            ms_cnt   <= '0;
            tone_cnt <= '0;
            cur_div  <= '0;
            cur_dur  <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state   <= IDLE;
                busy    <= 1'b0;
                speaker <= 1'b0;
                pre_cnt <= '0;
                ms_cnt  <= '0;
            end else if (enter_note) begin
                state    <= NOTE;
                busy     <= 1'b1;
                note_idx <= enter_idx;
                cur_div  <= div_mem[enter_idx];
                cur_dur  <= dur_mem[enter_idx];
                pre_cnt  <= '0;
                ms_cnt   <= '0;
                tone_cnt <= '0;
                speaker  <= 1'b0;
            end else begin
                case (state)
                    NOTE: begin
                        if (state_end) begin
                            state   <= GAP;
                            speaker <= 1'b0;
                            pre_cnt <= '0;
                            ms_cnt  <= '0;
                        end else begin
                            if (ms_tick) begin
                                pre_cnt <= '0;
                                ms_cnt  <= ms_cnt + MS_W'(1);
                            end else begin
                                pre_cnt <= pre_cnt + PRE_W'(1);
                            end
                            // Toggle every cur_div cycles; a zero divider is a rest.
                            if (cur_div != '0) begin
                                if (tone_cnt == cur_div - DIV_W'(1)) begin
                                    tone_cnt <= '0;
                                    speaker  <= ~speaker;
                                end else begin
                                    tone_cnt <= tone_cnt + DIV_W'(1);
                                end
                            end else begin
                                speaker <= 1'b0;
                            end
                        end
                    end
                    GAP: begin
                        if (state_end) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pre_cnt <= '0;
                            ms_cnt  <= '0;
                        end else if (ms_tick) begin
                            pre_cnt <= '0;
                            ms_cnt  <= ms_cnt + MS_W'(1);
                        end else begin
                            pre_cnt <= pre_cnt + PRE_W'(1);
                        end
                    end
                    default: begin
                        speaker <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
